prog_counter_stack: RTL and testbench

Parametrised program counter with an integrated hardware return-address stack, the successor to the 6-bit sequencer PC. It keeps the load/increment/clear behaviour and adds subroutine call and return. It has configurable address width and stack depth, plus overflow and underflow detection. It sits between the control FSM and the program memory address port, and drives the fetch address directly from a register.

---
 rtl/prog_counter_stack.sv | 151 +++++++++++++++
 tb/tb_prog_counter_stack.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter_stack.sv
// ---------------------------------------------------------------------------
// prog_counter_stack
//
// Program counter with an integrated return-address stack. It drives the
// program memory fetch address straight from a register and supports jump,
// increment, clear, subroutine call (push PC+1) and return (pop into PC).
// Overflowing calls and underflowing returns are suppressed and latch a
// sticky error flag.
//
// Parameters:
//   ADDR_W     - width of the PC, jump target and stack entries
//   DEPTH      - number of return-address entries (>= 1)
//   RESET_ADDR - PC value after rst or clear_PC
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   rst         - asynchronous active-high reset
//   ce          - clock enable; low holds all state
//   clear_PC    - PC to RESET_ADDR, stack emptied, stack_err cleared
//   ret_PC      - PC to top of stack, pop
//   call_PC     - push PC+1, PC to ADR_IN
//   load_PC     - PC to ADR_IN
//   enable_PC   - PC to PC+1
//   ADR_IN      - jump / call target
//   ADR_OUT     - current PC (registered)
//   SP_OUT      - number of valid stack entries
//   stack_full  - SP_OUT == DEPTH
//   stack_empty - SP_OUT == 0
//   stack_err   - sticky overflow/underflow flag
// ---------------------------------------------------------------------------
module prog_counter_stack #(
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  localparam int SP_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              clear_PC,
  input  logic              load_PC,
  input  logic              enable_PC,
  input  logic              call_PC,
  input  logic              ret_PC,
  input  logic [ADDR_W-1:0] ADR_IN,
  output logic [ADDR_W-1:0] ADR_OUT,
  output logic [SP_W-1:0]   SP_OUT,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic              err_reg, err_next;
  logic              push_en;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top_entry;
  logic [DEPTH-1:0]  wr_sel;

  // Return-address storage; no reset needed since entries at or above SP
  // are never observable.
  logic [ADDR_W-1:0] entry_reg [DEPTH];

  // Flags come from the SP register only, never from the command inputs.
  assign stack_full  = (sp_reg == SP_W'(DEPTH));
  assign stack_empty = (sp_reg == '0);

  assign ADR_OUT   = pc_reg;
  assign SP_OUT    = sp_reg;
  assign stack_err = err_reg;

  // Natural wrap modulo 2^ADDR_W; the same value is pushed on a call, so a
  // call from all-ones pushes zero.
  assign pc_inc = pc_reg + ADDR_W'(1);

  // Top-of-stack is entry[SP-1]; decoded by compare so the index never
  // needs to be narrowed to the array bounds.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_reg == SP_W'(i + 1)) begin
        top_entry = entry_reg[i];
      end
    end
  end

  // Command decode with fixed priority clear > ret > call > load > enable.
  always_comb begin
    pc_next  = pc_reg;
    sp_next  = sp_reg;
    err_next = err_reg;
    push_en  = 1'b0;
    if (ce) begin
      if (clear_PC) begin
        pc_next  = ADDR_W'(RESET_ADDR);
        sp_next  = '0;
        err_next = 1'b0;
      end else if (ret_PC) begin
        if (stack_empty) begin
          err_next = 1'b1;
        end else begin
          pc_next = top_entry;
          sp_next = sp_reg - SP_W'(1);
        end
      end else if (call_PC) begin
        // A call that would overflow is dropped entirely, jump included.
        if (stack_full) begin
          err_next = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_next = sp_reg + SP_W'(1);
          pc_next = ADR_IN;
        end
      end else if (load_PC) begin
        pc_next = ADR_IN;
      end else if (enable_PC) begin
        pc_next = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg  <= ADDR_W'(RESET_ADDR);
      sp_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      sp_reg  <= sp_next;
      err_reg <= err_next;
    end
  end

  // One-hot write select: the push lands in entry[SP].
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = push_en && (sp_reg == SP_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) begin
        entry_reg[i] <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_prog_counter_stack.sv
// ---------------------------------------------------------------------------
// tb_prog_counter_stack
//
// Self-checking bench for prog_counter_stack (ADDR_W=6, DEPTH=4). Directed
// scenarios followed by randomized commands, all compared against a
// queue-based reference model of the PC and its return stack.
// ---------------------------------------------------------------------------
module tb_prog_counter_stack;

  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 4;
  localparam int RESET_ADDR = 0;
  localparam int SP_W       = $clog2(DEPTH + 1);
  localparam int PC_MOD     = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              ce;
  logic              clear_PC;
  logic              load_PC;
  logic              enable_PC;
  logic              call_PC;
  logic              ret_PC;
  logic [ADDR_W-1:0] adr_in;
  logic [ADDR_W-1:0] adr_out;
  logic [SP_W-1:0]   sp_out;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  prog_counter_stack #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .clear_PC   (clear_PC),
    .load_PC    (load_PC),
    .enable_PC  (enable_PC),
    .call_PC    (call_PC),
    .ret_PC     (ret_PC),
    .ADR_IN     (adr_in),
    .ADR_OUT    (adr_out),
    .SP_OUT     (sp_out),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;
  int n_cyc;

  // Reference model: PC as an integer, the return stack as a queue.
  int m_pc;
  int m_stack[$];
  bit m_err;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_ADDR;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit clr, input bit rt, input bit cl,
                            input bit ld, input bit en, input int adr);
    if (!c) return;
    if (clr) begin
      model_reset();
    end else if (rt) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (cl) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stack.push_back((m_pc + 1) % PC_MOD);
        m_pc = adr;
      end
    end else if (ld) begin
      m_pc = adr;
    end else if (en) begin
      m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  task automatic check_all(input string tag);
    check_value({tag, ".pc"},    int'(adr_out),     m_pc);
    check_value({tag, ".sp"},    int'(sp_out),      m_stack.size());
    check_value({tag, ".full"},  int'(stack_full),  int'(m_stack.size() == DEPTH));
    check_value({tag, ".empty"}, int'(stack_empty), int'(m_stack.size() == 0));
    check_value({tag, ".err"},   int'(stack_err),   int'(m_err));
  endtask

  // One clock: drive, let the edge happen, update model, sample 1 ns later.
  task automatic do_cycle(input string tag, input bit c, input bit clr, input bit rt,
                          input bit cl, input bit ld, input bit en, input int adr);
    ce        = c;
    clear_PC  = clr;
    ret_PC    = rt;
    call_PC   = cl;
    load_PC   = ld;
    enable_PC = en;
    adr_in    = ADDR_W'(adr);
    @(posedge clk);
    model_step(c, clr, rt, cl, ld, en, adr);
    #1;
    n_cyc++;
    $display("cyc %0d %s ce=%0b clr=%0b ret=%0b call=%0b ld=%0b en=%0b adr=%0d -> pc=%0d sp=%0d err=%0b",
             n_cyc, tag, c, clr, rt, cl, ld, en, adr, adr_out, sp_out, stack_err);
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_cyc = 0;
    ce = 1'b0; clear_PC = 1'b0; load_PC = 1'b0; enable_PC = 1'b0;
    call_PC = 1'b0; ret_PC = 1'b0; adr_in = '0;
    rst = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    rst = 1'b0;

    // Reset and increment: 65 increments run through the wrap.
    for (int i = 0; i < 65; i++) do_cycle("inc", 1, 0, 0, 0, 0, 1, 0);
    check_value("inc_wrap_pc", int'(adr_out), 1);

    // Nested calls and returns from PC=5.
    do_cycle("nest_ld", 1, 0, 0, 0, 1, 0, 5);
    do_cycle("nest_c1", 1, 0, 0, 1, 0, 0, 20);
    do_cycle("nest_c2", 1, 0, 0, 1, 0, 0, 40);
    do_cycle("nest_r1", 1, 0, 1, 0, 0, 0, 0);
    check_value("nest_r1_pc", int'(adr_out), 21);
    do_cycle("nest_r2", 1, 0, 1, 0, 0, 0, 0);
    check_value("nest_r2_pc", int'(adr_out), 6);

    // Overflow: four calls fill the stack, the fifth is dropped.
    for (int i = 0; i < DEPTH; i++) do_cycle("ovf_call", 1, 0, 0, 1, 0, 0, 10 + i);
    do_cycle("ovf_5th", 1, 0, 0, 1, 0, 0, 9);
    check_value("ovf_sp", int'(sp_out), 4);
    check_value("ovf_err", int'(stack_err), 1);
    do_cycle("ovf_clr", 1, 1, 0, 0, 0, 0, 0);

    // Underflow from reset, then increment keeps the sticky flag.
    pulse_reset("unf_rst");
    do_cycle("unf_ret", 1, 0, 1, 0, 0, 0, 0);
    do_cycle("unf_inc", 1, 0, 0, 0, 0, 1, 0);
    check_value("unf_inc_pc", int'(adr_out), 1);

    // Priority: call beats load and enable; ret shows the pushed entry.
    do_cycle("pri_ld", 1, 0, 0, 0, 1, 0, 3);
    do_cycle("pri_all", 1, 0, 0, 1, 1, 1, 12);
    do_cycle("pri_ret", 1, 0, 1, 0, 0, 0, 0);
    check_value("pri_ret_pc", int'(adr_out), 4);
    // Clear beats ret even with a stack entry present.
    do_cycle("pri_c", 1, 0, 0, 1, 0, 0, 30);
    do_cycle("pri_clr", 1, 1, 1, 1, 1, 1, 7);

    // ce low: everything toggles, nothing changes.
    do_cycle("ce_pre", 1, 0, 0, 1, 0, 0, 17);
    for (int i = 0; i < 5; i++)
      do_cycle("ce0", 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), int'($urandom_range(0, PC_MOD - 1)));

    // Wrap on call: call from 63 pushes 0.
    do_cycle("wrap_ld", 1, 0, 0, 0, 1, 0, 63);
    do_cycle("wrap_call", 1, 0, 0, 1, 0, 0, 33);
    do_cycle("wrap_ret", 1, 0, 1, 0, 0, 0, 0);
    check_value("wrap_ret_pc", int'(adr_out), 0);

    // Asynchronous reset with three entries on the stack.
    do_cycle("mid_clr", 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_cycle("mid_call", 1, 0, 0, 1, 0, 0, 50 + i);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_value("mid_rst_pc", int'(adr_out), 0);
    check_value("mid_rst_sp", int'(sp_out), 0);
    check_all("mid_rst");
    #1;
    rst = 1'b0;

    // Randomized commands, weighted toward call/ret so both limits are hit.
    for (int i = 0; i < 400; i++) begin
      int r;
      bit c, clr, rt, cl, ld, en;
      r   = int'($urandom_range(0, 99));
      c   = ($urandom_range(0, 9) != 0);
      clr = (r < 3);
      rt  = (r >= 3  && r < 38) || ($urandom_range(0, 7) == 0);
      cl  = (r >= 38 && r < 73) || ($urandom_range(0, 7) == 0);
      ld  = (r >= 73 && r < 83) || ($urandom_range(0, 3) == 0);
      en  = (r >= 83) || ($urandom_range(0, 3) == 0);
      do_cycle("rand", c, clr, rt, cl, ld, en, int'($urandom_range(0, PC_MOD - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
